div25x9_seq: RTL and testbench

//  Iterative restoring divider; inverse of the 16x9 multiplier datapath.

---
 rtl/div25x9_seq.sv | 135 +++++++++++++
 tb/tb_div25x9_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/div25x9_seq.sv
// div25x9_seq: iterative restoring divider, valid/ready in and out; DIV_RADIX4_EN retires two quotient bits per cycle
module div25x9_seq #(
  parameter int DD_WD = 25,
  parameter int DR_WD = 9,
  parameter int QT_WD = DD_WD - DR_WD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DD_WD-1:0] A,
  input  logic [DR_WD-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QT_WD-1:0] Q,
  output logic [DR_WD-1:0] R,
  output logic             ovf,
  output logic             dbz
);
`ifdef DIV_RADIX4_EN
  localparam int AW = DD_WD + (DD_WD % 2);
  localparam int NC = AW / 2;
`else
  localparam int AW = DD_WD;
  localparam int NC = DD_WD;
`endif
  localparam int CW = $clog2(NC + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] a_q, a_d, a_n, quo_q, quo_d, quo_n;
  logic [DR_WD-1:0] b_q, b_d, r_q, r_d;
  logic [DR_WD:0] rem_q, rem_d, rem_n, t1, r1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QT_WD-1:0] q_q, q_d;
  logic ovf_q, ovf_d, dbz_q, dbz_d, g1;
`ifdef DIV_RADIX4_EN
  logic [DR_WD:0] t2, r2;
  logic g2;
`endif
  // one (or two) restoring compare/subtract steps on the partial remainder, MSB first
  always_comb begin
    t1 = {DR_WD'(rem_q), a_q[AW-1]};
    g1 = t1 >= {1'b0, b_q};
    r1 = g1 ? t1 - {1'b0, b_q} : t1;
`ifdef DIV_RADIX4_EN
    t2 = {DR_WD'(r1), a_q[AW-2]};
    g2 = t2 >= {1'b0, b_q};
    r2 = g2 ? t2 - {1'b0, b_q} : t2;
    rem_n = r2;
    quo_n = {quo_q[AW-3:0], g1, g2};
    a_n = {a_q[AW-3:0], 2'b00};
`else
    rem_n = r1;
    quo_n = {quo_q[AW-2:0], g1};
    a_n = {a_q[AW-2:0], 1'b0};
`endif
  end
  // FSM next state, operand latching and result capture on entry to DONE
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    q_d = q_q;
    r_d = r_q;
    ovf_d = ovf_q;
    dbz_d = dbz_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (B == '0) begin
          state_d = DONE;
          dbz_d = 1'b1;
          q_d = '1;
          r_d = A[DR_WD-1:0];
          ovf_d = 1'b0;
        end else begin
          state_d = CALC;
          a_d = AW'(A);
          b_d = B;
          rem_d = '0;
          cnt_d = CW'(NC);
        end
      end
      CALC: begin
        a_d = a_n;
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          q_d = quo_n[QT_WD-1:0];
          r_d = DR_WD'(rem_n);
          ovf_d = |quo_n[AW-1:QT_WD];
          dbz_d = 1'b0;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      q_q <= '0;
      r_q <= '0;
      ovf_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      r_q <= r_d;
      ovf_q <= ovf_d;
      dbz_q <= dbz_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign Q = q_q;
  assign R = r_q;
  assign ovf = ovf_q;
  assign dbz = dbz_q;
endmodule

// File: tb/tb_div25x9_seq.sv
// tb_div25x9_seq: directed and random checks of div25x9_seq against plain integer division
module tb_div25x9_seq;
`ifdef DIV_RADIX4_EN
  localparam int LAT = 14;
`else
  localparam int LAT = 26;
`endif
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [24:0] A = '0;
  logic [8:0] B = '0;
  logic in_ready, out_valid, ovf, dbz;
  logic [15:0] Q;
  logic [8:0] R;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  div25x9_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .Q(Q), .R(R), .ovf(ovf), .dbz(dbz)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic [24:0] a, input logic [8:0] b, input int stall, input bit chk_lat);
    int lat;
    int unsigned full;
    logic [15:0] xq;
    logic [8:0] xr;
    logic xo, xd;
    if (b == 0) begin
      xd = 1; xq = 16'hFFFF; xr = a[8:0]; xo = 0;
    end else begin
      full = 32'(a) / 32'(b);
      xd = 0; xq = full[15:0]; xr = 9'(32'(a) % 32'(b)); xo = full >= 32'd65536;
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 0; A = 25'($urandom); B = 9'($urandom);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (chk_lat) chk("latency", lat, (b == 0) ? 1 : LAT);
    repeat (stall) begin
      in_valid = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("out_valid", out_valid, 1);
    chk("in_ready_busy", in_ready, 0);
    chk("Q", Q, xq);
    chk("R", R, xr);
    chk("ovf", ovf, xo);
    chk("dbz", dbz, xd);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("out_valid_clr", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("Q_hold", Q, xq);
  endtask
  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_Q", Q, 0);
    chk("rst_R", R, 0);
    chk("rst_flags", {ovf, dbz}, 0);
    @(posedge clk); #1 rst = 0;
    do_op(25'd300000, 9'd300, 0, 1);
    do_op(25'd300007, 9'd300, 3, 1);
    do_op(25'd33554431, 9'd511, 0, 1);
    do_op(25'd12345, 9'd0, 2, 1);
    do_op(25'd33488385, 9'd511, 10, 1);
    in_valid = 1; A = 25'd1000000; B = 9'd7;
    @(posedge clk); #1 in_valid = 0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_Q", Q, 0);
    @(posedge clk); #1 rst = 0;
    do_op(25'd9, 9'd2, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      logic [8:0] b;
      b = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 3)) : 9'($urandom_range(0, 511));
      do_op(25'($urandom), b, $urandom_range(0, 3), 1);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
